// File: rtl/turbo_clkgen.sv
// turbo_clkgen: fixed-rate clock enables plus a glitch-free CPU turbo divider with SDRAM stall.
module turbo_clkgen #(
  parameter int TW        = 5,
  parameter int CNT_W     = 6,
  parameter int SETTLE    = 2,
  parameter int WAIT_ONES = 3
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [TW-1:0] turbo_req,
  input  logic          std_ce_p,
  input  logic          std_ce_n,
  input  logic          ram_ready,
  input  logic          strict_wait,
  output logic          ce_28m,
  output logic          ce_7mp,
  output logic          ce_7mn,
  output logic          ce_psg,
  output logic          ce_cpu_p,
  output logic          ce_cpu_n,
  output logic          ce_cpu,
  output logic [TW-1:0] turbo,
  output logic          cpu_en,
  output logic          busy
);
  typedef enum logic [1:0] {RUN, HOLD, STALL} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TW-1:0]    masked, req_clean;
  logic [2:0]       tmo;
  logic             tp, tn, cpu_p, cpu_n, req_therm, change, stall_req;
  assign masked    = cnt[TW-1:0] & turbo;
  // Anything but a thermometer mask from the LSB falls back to normal speed.
  assign req_therm = (turbo_req != '0) && ((turbo_req & (turbo_req + TW'(1))) == '0);
  assign req_clean = req_therm ? turbo_req : '1;
  assign change    = req_clean != turbo;
  assign stall_req = !ram_ready && ($countones(turbo) < (strict_wait ? WAIT_ONES + 1 : WAIT_ONES));
  assign cpu_p     = &turbo ? std_ce_p : tp;
  assign cpu_n     = &turbo ? std_ce_n : tn;
  assign ce_cpu_p  = cpu_en & cpu_p;
  assign ce_cpu_n  = cpu_en & cpu_n;
  assign ce_cpu    = cpu_en & tp;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt    <= '0;
      ce_28m <= 1'b0;
      ce_7mp <= 1'b0;
      ce_7mn <= 1'b0;
      ce_psg <= 1'b0;
      tp     <= 1'b0;
      tn     <= 1'b0;
    end else begin
      cnt    <= cnt + CNT_W'(1);
      ce_28m <= cnt[1:0] == 2'd0;
      ce_7mp <= cnt[3:0] == 4'd0;
      ce_7mn <= cnt[3:0] == 4'd8;
      ce_psg <= cnt == '0;
      tp     <= masked == '0;
      tn     <= (masked ^ turbo ^ (turbo >> 1)) == '0;
    end
  end
  // The FSM only moves on a cpu_n strobe, so mask swaps land between CPU half-cycles.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state  <= RUN;
      turbo  <= '1;
      cpu_en <= 1'b1;
      busy   <= 1'b0;
      tmo    <= '0;
    end else if (cpu_n) begin
      if (change) begin
        turbo  <= req_clean;
        cpu_en <= 1'b0;
        tmo    <= '0;
        busy   <= 1'b1;
        state  <= HOLD;
      end else if (state == RUN) begin
        if (stall_req) begin
          cpu_en <= 1'b0;
          state  <= STALL;
        end
      end else if (state == STALL) begin
        if (ram_ready) begin
          cpu_en <= 1'b1;
          state  <= RUN;
        end
      end else if (tmo == 3'(SETTLE)) begin
        if (ram_ready) begin
          cpu_en <= 1'b1;
          busy   <= 1'b0;
          state  <= RUN;
        end
      end else begin
        tmo <= tmo + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_turbo_clkgen.sv
// tb_turbo_clkgen: scoreboard bench for turbo_clkgen strobes, turbo switching and SDRAM stalls.
module tb_turbo_clkgen;
  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] turbo_req = 5'b11111;
  logic       std_ce_p = 1'b0, std_ce_n = 1'b0, ram_ready = 1'b1, strict_wait = 1'b0;
  logic       ce_28m, ce_7mp, ce_7mn, ce_psg, ce_cpu_p, ce_cpu_n, ce_cpu, cpu_en, busy;
  logic [4:0] turbo;
  int         errors = 0, checks = 0, cyc = 0, m_cnt = 0;
  bit         std_on = 1'b0;
  logic       m_tp = 1'b0, m_tn = 1'b0;
  logic [4:0] m_turbo = 5'b11111;
  logic [3:0] exp_q[$];

  turbo_clkgen dut (
    .clk_sys(clk_sys), .reset(reset), .turbo_req(turbo_req), .std_ce_p(std_ce_p),
    .std_ce_n(std_ce_n), .ram_ready(ram_ready), .strict_wait(strict_wait),
    .ce_28m(ce_28m), .ce_7mp(ce_7mp), .ce_7mn(ce_7mn), .ce_psg(ce_psg),
    .ce_cpu_p(ce_cpu_p), .ce_cpu_n(ce_cpu_n), .ce_cpu(ce_cpu), .turbo(turbo),
    .cpu_en(cpu_en), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic exp_cpu_n();
    return (&m_turbo) ? std_ce_n : m_tn;
  endfunction

  task automatic step();
    logic [3:0] e, got;
    logic [4:0] c5;
    c5 = m_cnt[4:0];
    e = reset ? 4'd0 : {m_cnt % 4 == 0, m_cnt % 16 == 0, m_cnt % 16 == 8, m_cnt == 0};
    exp_q.push_back(e);
    if (reset) begin
      m_cnt = 0; m_tp = 1'b0; m_tn = 1'b0;
    end else begin
      m_tp  = (c5 & m_turbo) == 5'd0;
      m_tn  = ((c5 & m_turbo) ^ m_turbo ^ (m_turbo >> 1)) == 5'd0;
      m_cnt = (m_cnt + 1) % 64;
    end
    @(posedge clk_sys); #1;
    cyc++;
    std_ce_n = std_on && (cyc % 32 == 0);
    std_ce_p = std_on && (cyc % 32 == 16);
    got = {ce_28m, ce_7mp, ce_7mn, ce_psg};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL strobes cyc=%0d got=%b exp=%b", cyc, got, e);
    end
  endtask

  task automatic change_turbo(input logic [4:0] req, input logic [4:0] exp_mask);
    bit found = 1'b0;
    turbo_req = req;
    for (int i = 0; i < 80 && !found; i++) begin
      found = exp_cpu_n();
      step();
    end
    m_turbo = exp_mask;
    checks++;
    if (!found || turbo !== exp_mask || busy !== 1'b1 || cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL change req=%b strobe=%0b turbo=%b exp=%b busy=%b cpu_en=%b", req, found, turbo, exp_mask, busy, cpu_en);
    end
  endtask

  task automatic settle();
    int n = 0;
    for (int i = 0; i < 150 && n < 3; i++) begin
      checks++;
      if ({ce_cpu_p, ce_cpu_n, ce_cpu, cpu_en} !== 4'b0) begin
        errors++;
        $display("FAIL pause cyc=%0d p=%b n=%b ce=%b en=%b exp 0", cyc, ce_cpu_p, ce_cpu_n, ce_cpu, cpu_en);
      end
      if (exp_cpu_n()) n++;
      step();
    end
    checks++;
    if (n != 3 || cpu_en !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL settle strobes=%0d cpu_en=%b busy=%b exp 3/1/0", n, cpu_en, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (turbo !== 5'b11111 || cpu_en !== 1'b1 || busy !== 1'b0 || ce_cpu !== 1'b0 || ce_cpu_p !== 1'b0) begin
      errors++;
      $display("FAIL reset turbo=%b cpu_en=%b busy=%b ce_cpu=%b exp 11111/1/0/0", turbo, cpu_en, busy, ce_cpu);
    end
  endtask

  task automatic test_free_run();
    int psg = 0;
    reset = 1'b0;
    for (int i = 0; i < 140; i++) begin
      step();
      psg += int'(ce_psg);
      checks++;
      if (ce_cpu !== m_tp || cpu_en !== 1'b1) begin
        errors++;
        $display("FAIL free_ce_cpu cyc=%0d got=%b exp=%b cpu_en=%b", cyc, ce_cpu, m_tp, cpu_en);
      end
    end
    checks++;
    if (psg != 3 || turbo !== 5'b11111) begin
      errors++;
      $display("FAIL free_psg count=%0d exp 3 turbo=%b", psg, turbo);
    end
  endtask

  task automatic test_turbo_up();
    std_on = 1'b1;
    change_turbo(5'b00001, 5'b00001);
    settle();
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (ce_cpu_p !== m_tp || ce_cpu_n !== m_tn || ce_cpu_p === ce_cpu_n) begin
        errors++;
        $display("FAIL alternate cyc=%0d p=%b n=%b exp %b/%b", cyc, ce_cpu_p, ce_cpu_n, m_tp, m_tn);
      end
    end
  endtask

  task automatic test_stall();
    bit stalled = 1'b0, found = 1'b0, was;
    change_turbo(5'b00011, 5'b00011);
    settle();
    ram_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      was = exp_cpu_n();
      step();
      if (was) stalled = 1'b1;
      checks++;
      if (cpu_en !== logic'(!stalled)) begin
        errors++;
        $display("FAIL stall_enter cyc=%0d cpu_en=%b exp %b", cyc, cpu_en, !stalled);
      end
    end
    ram_ready = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      was = exp_cpu_n();
      step();
      if (was) found = 1'b1;
      checks++;
      if (cpu_en !== logic'(found) || busy !== 1'b0) begin
        errors++;
        $display("FAIL stall_exit cyc=%0d cpu_en=%b exp %b busy=%b", cyc, cpu_en, found, busy);
      end
    end
  endtask

  task automatic test_strict_wait();
    bit found = 1'b0, was;
    change_turbo(5'b00111, 5'b00111);
    settle();
    ram_ready = 1'b0;
    strict_wait = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (cpu_en !== 1'b1) begin
        errors++;
        $display("FAIL no_stall cyc=%0d cpu_en=%b exp 1", cyc, cpu_en);
      end
    end
    strict_wait = 1'b1;
    for (int i = 0; i < 12 && !found; i++) begin
      was = exp_cpu_n();
      step();
      if (was) found = 1'b1;
      checks++;
      if (cpu_en !== logic'(!found)) begin
        errors++;
        $display("FAIL strict_stall cyc=%0d cpu_en=%b exp %b", cyc, cpu_en, !found);
      end
    end
    ram_ready = 1'b1;
    strict_wait = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      found = exp_cpu_n();
      step();
    end
    checks++;
    if (!found || cpu_en !== 1'b1) begin
      errors++;
      $display("FAIL strict_resume strobe=%0b cpu_en=%b exp 1", found, cpu_en);
    end
  endtask

  task automatic test_hold_retarget();
    int n = 0;
    change_turbo(5'b00011, 5'b00011);
    for (int i = 0; i < 20 && n < 1; i++) begin
      if (exp_cpu_n()) n++;
      step();
    end
    change_turbo(5'b01111, 5'b01111);
    n = 0;
    for (int i = 0; i < 50 && n < 2; i++) begin
      if (exp_cpu_n()) n++;
      step();
    end
    checks++;
    if (n != 2 || cpu_en !== 1'b0 || busy !== 1'b1 || turbo !== 5'b01111) begin
      errors++;
      $display("FAIL tmo_restart strobes=%0d cpu_en=%b busy=%b turbo=%b exp 2/0/1/01111", n, cpu_en, busy, turbo);
    end
    std_on = 1'b0;
    reset = 1'b1;
    step();
    m_turbo = 5'b11111;
    checks++;
    if (turbo !== 5'b11111 || cpu_en !== 1'b1 || busy !== 1'b0 || ce_cpu !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset turbo=%b cpu_en=%b busy=%b ce_cpu=%b exp 11111/1/0/0", turbo, cpu_en, busy, ce_cpu);
    end
    reset = 1'b0;
  endtask

  task automatic test_bad_req();
    logic [4:0] bad[3] = '{5'b00101, 5'b00000, 5'b10000};
    std_on = 1'b1;
    foreach (bad[k]) begin
      turbo_req = bad[k];
      for (int i = 0; i < 40; i++) begin
        step();
        checks++;
        if (turbo !== 5'b11111 || busy !== 1'b0 || cpu_en !== 1'b1) begin
          errors++;
          $display("FAIL bad_req req=%b turbo=%b busy=%b cpu_en=%b exp 11111/0/1", bad[k], turbo, busy, cpu_en);
        end
      end
    end
    change_turbo(5'b00001, 5'b00001);
    settle();
    change_turbo(5'b00101, 5'b11111);
    settle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_free_run();
    test_turbo_up();
    test_stall();
    test_strict_wait();
    test_hold_retarget();
    test_bad_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/turbo_clkgen.md
# turbo_clkgen

Parametrised clock-enable and CPU turbo controller for the Spectrum core. It derives all fixed-rate strobes (28 MHz, 7 MHz pos/neg, PSG) from `clk_sys` and generates the CPU `CEN_p`/`CEN_n` pair at a selectable turbo level. Turbo changes are glitch-free: the CPU is paused, the divider is switched, and the CPU resumes after a settle period. The block also stalls the CPU on SDRAM not-ready at high turbo levels. It sits between the PLL output and the T80 core, ULA video timing and the SDRAM controller.

## Interface
Parameters:
- `TW`, 5, turbo mask width; mask `{TW{1'b1}}` = normal speed (clk_sys/2^TW), `1` = fastest (clk_sys/2)
- `CNT_W`, 6, free-running divider width; must be ≥ max(TW, 4); PSG strobe period = 2^CNT_W
- `SETTLE`, 2, cpu_n strobes CPU stays paused after a turbo change (1..7)
- `WAIT_ONES`, 3, `!ram_ready` stalls the CPU when the current mask has fewer than WAIT_ONES ones

Ports:
- `clk_sys` in 1: system clock, the only clock
- `reset` in 1: synchronous, active-high
- `turbo_req` in TW: requested mask; legal values are thermometer masks from LSB (`00001`..`11111`)
- `std_ce_p` in 1: contended CPU posedge enable from video; used at normal speed
- `std_ce_n` in 1: contended CPU negedge enable from video; used at normal speed
- `ram_ready` in 1: SDRAM idle/ready
- `strict_wait` in 1: stall threshold becomes WAIT_ONES+1 (tape load)
- `ce_28m`, `ce_7mp`, `ce_7mn`, `ce_psg` out 1: fixed-rate strobes
- `ce_cpu_p`, `ce_cpu_n` out 1: gated CPU enables
- `ce_cpu` out 1: `cpu_en & tp`, the ungated-rate peripheral strobe
- `turbo` out TW: mask currently in effect
- `cpu_en` out 1: CPU running
- `busy` out 1: high in HOLD state

## Operation
- Divider: `cnt` increments every cycle. Strobe registers are computed from the pre-increment `cnt`:
  - `ce_28m = cnt[1:0]==0`
  - `ce_7mp = cnt[3:0]==0`
  - `ce_7mn = cnt[3:0]==8`
  - `ce_psg = cnt==0`
  - `tp = (cnt & turbo)==0`
  - `tn = ((cnt & turbo) ^ turbo ^ (turbo>>1))==0`
- Select: `cpu_p/cpu_n = (&turbo) ? std_ce_p/std_ce_n : tp/tn`.
- Outputs: `ce_cpu_p = cpu_en & cpu_p`; `ce_cpu_n = cpu_en & cpu_n`.
- Request sanitising: a non-thermometer or zero `turbo_req` is treated as all-ones.
- FSM (advances only in cycles where `cpu_n`=1):
  - RUN:
    - clean request ≠ `turbo` → `turbo`←request, `cpu_en`←0, `tmo`←0, go to HOLD.
    - Otherwise, if `!ram_ready` and popcount(`turbo`) < (`strict_wait` ? WAIT_ONES+1 : WAIT_ONES) → `cpu_en`←0, go to STALL.
  - HOLD:
    - Request differs again → reload `turbo`, `tmo`←0, stay in HOLD.
    - Otherwise `tmo`++; once `tmo`==SETTLE and `ram_ready` → `cpu_en`←1, go to RUN.
  - STALL:
    - Request differs → behave as RUN change (go to HOLD).
    - Otherwise `ram_ready` → `cpu_en`←1, go to RUN.
- Turbo changes are accepted only when the stall condition is evaluated after the change check, so a change always wins over a stall.
- At normal speed the FSM advances on `std_ce_n`. If video stops producing `std_ce_n`, the FSM freezes. This is intended.

## Timing
- Reset values: `cnt`=0, all strobe outputs 0, `turbo`=all-ones, `cpu_en`=1, state RUN, `busy`=0, `tmo`=0.
- Strobes are registered and appear one cycle after the matching `cnt` value. After reset release, `ce_28m`/`ce_7mp`/`ce_psg` first assert in cycle 2.
- `cpu_en` and `turbo` update on the same edge that consumes the `cpu_n` strobe. The new mask's `tp`/`tn` are effective from the next cycle.
- No `ce_cpu_p`/`ce_cpu_n` pulse is emitted between the change edge and re-enable.
- Minimum pause after a change is SETTLE+1 strobes of the new `cpu_n` rate.
- `cnt` wraps modulo 2^CNT_W with no discontinuity. A mid-operation reset returns to the reset state within one cycle, including from HOLD/STALL.

## Test plan
- Reset, then free run with TW=5 and CNT_W=6:
  - `ce_28m` every 4 cycles, `ce_7mp`/`ce_7mn` 8 cycles apart with period 16, `ce_psg` period 64.
  - `turbo`=11111 and `cpu_en`=1.
- Drive `std_ce_n` every 32 cycles and set `turbo_req`=00001:
  - `cpu_en` drops on the next `std_ce_n` and `busy`=1.
  - After 3 `tn` strobes with `ram_ready`=1, `cpu_en`=1.
  - `ce_cpu_p` then alternates with `ce_cpu_n` every cycle.
- At `turbo`=00011, drop `ram_ready` for 10 cycles:
  - `cpu_en`=0 from the next `cpu_n`.
  - `cpu_en` returns to 1 on the first `cpu_n` after `ram_ready`=1.
- At `turbo`=00111 with `ram_ready` low: no stall with `strict_wait`=0; stall with `strict_wait`=1.
- While in HOLD, change `turbo_req` 00011→01111: `tmo` restarts and `turbo`=01111; reassert `reset` mid-HOLD → reset values on the next cycle.
- Set `turbo_req`=00101: `turbo` stays/returns to 11111.
